// File: rtl/pe_packet_encoder.sv
// Response packet serialiser: ACK/NACK handshakes and DATA packets carrying the
// winning nonce and hash, emitted one byte at a time over a valid/ready stream.
module pe_packet_encoder #(
  parameter int          NONCE_BYTES = 4,
  parameter int          HASH_BYTES  = 32,
  parameter logic [7:0]  PID_ACK     = 8'hD2,
  parameter logic [7:0]  PID_NACK    = 8'h5A,
  parameter logic [7:0]  PID_DATA    = 8'hC3
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    transmit_ack,
  input  logic                    transmit_nack,
  input  logic                    result_valid,
  input  logic [NONCE_BYTES*8-1:0] nonce,
  input  logic [HASH_BYTES*8-1:0]  hash,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_eop,
  output logic                    tx_done,
  output logic                    busy,
  output logic                    result_overrun
);

  localparam int PAY = NONCE_BYTES + HASH_BYTES;
  localparam int IW  = $clog2(PAY);
  localparam logic [IW-1:0] LAST = IW'(PAY - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PID     = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_CHK     = 2'd3;

  localparam logic [1:0] T_ACK  = 2'd0;
  localparam logic [1:0] T_NACK = 2'd1;
  localparam logic [1:0] T_DATA = 2'd2;

  logic [1:0]          state, ptype;
  logic                ack_p, nack_p, data_p;
  logic [PAY-1:0][7:0] payload;
  logic [IW-1:0]       idx, next_idx;
  logic [7:0]          chk, chk_next;
  logic                xfer, idle, data_active, accept;
  logic                sel_ack, sel_nack, sel_data;

  assign xfer        = tx_valid & tx_ready;
  assign idle        = (state == S_IDLE);
  assign data_active = ~idle & (ptype == T_DATA);
  // A result is only captured when no DATA packet owns the payload registers.
  assign accept      = result_valid & ~data_p & ~data_active;

  assign sel_nack = idle & (nack_p | transmit_nack);
  assign sel_ack  = idle & ~(nack_p | transmit_nack) & (ack_p | transmit_ack);
  assign sel_data = idle & ~(nack_p | transmit_nack) & ~(ack_p | transmit_ack)
                  & (data_p | result_valid);

  assign next_idx = idx + 1'b1;
  assign chk_next = chk ^ tx_data;
  assign busy     = ~idle | ack_p | nack_p | data_p;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= S_IDLE;
      ptype          <= T_ACK;
      ack_p          <= 1'b0;
      nack_p         <= 1'b0;
      data_p         <= 1'b0;
      payload        <= '0;
      idx            <= '0;
      chk            <= '0;
      tx_valid       <= 1'b0;
      tx_data        <= 8'h00;
      tx_eop         <= 1'b0;
      tx_done        <= 1'b0;
      result_overrun <= 1'b0;
    end else begin
      tx_done        <= 1'b0;
      result_overrun <= result_valid & ~accept;

      // Selection consumes a fresh request; a repeat on top of a pending flag survives.
      ack_p  <= sel_ack  ? (ack_p & transmit_ack)   : (ack_p | transmit_ack);
      nack_p <= sel_nack ? (nack_p & transmit_nack) : (nack_p | transmit_nack);
      data_p <= sel_data ? 1'b0 : (data_p | accept);
      if (accept) payload <= {hash, nonce};

      case (state)
        S_IDLE: begin
          if (sel_nack | sel_ack | sel_data) begin
            state    <= S_PID;
            tx_valid <= 1'b1;
            if (sel_nack) begin
              ptype   <= T_NACK;
              tx_data <= PID_NACK;
              tx_eop  <= 1'b1;
            end else if (sel_ack) begin
              ptype   <= T_ACK;
              tx_data <= PID_ACK;
              tx_eop  <= 1'b1;
            end else begin
              ptype   <= T_DATA;
              tx_data <= PID_DATA;
              tx_eop  <= 1'b0;
            end
          end
        end
        S_PID: begin
          if (xfer) begin
            if (ptype == T_DATA) begin
              state   <= S_PAYLOAD;
              idx     <= '0;
              chk     <= 8'h00;
              tx_data <= payload[0];
            end else begin
              state    <= S_IDLE;
              tx_valid <= 1'b0;
              tx_eop   <= 1'b0;
              tx_data  <= 8'h00;
              tx_done  <= 1'b1;
            end
          end
        end
        S_PAYLOAD: begin
          if (xfer) begin
            chk <= chk_next;
            if (idx == LAST) begin
              state   <= S_CHK;
              tx_data <= chk_next;
              tx_eop  <= 1'b1;
            end else begin
              idx     <= next_idx;
              tx_data <= payload[next_idx];
            end
          end
        end
        default: begin
          if (xfer) begin
            state    <= S_IDLE;
            tx_valid <= 1'b0;
            tx_eop   <= 1'b0;
            tx_data  <= 8'h00;
            tx_done  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_packet_encoder.sv
// Self-checking bench for pe_packet_encoder: a bus monitor records every accepted
// byte, and each scenario compares it against byte lists built from the packet format.
module tb_pe_packet_encoder;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         transmit_ack, transmit_nack, result_valid, tx_ready;
  logic [31:0]  nonce;
  logic [255:0] hash;
  logic         tx_valid, tx_eop, tx_done, busy, result_overrun;
  logic [7:0]   tx_data;

  pe_packet_encoder dut (
    .clk(clk), .n_rst(n_rst), .transmit_ack(transmit_ack), .transmit_nack(transmit_nack),
    .result_valid(result_valid), .nonce(nonce), .hash(hash), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_eop(tx_eop), .tx_done(tx_done),
    .busy(busy), .result_overrun(result_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, ovr_cnt = 0, stall_err = 0;
  logic [8:0] rx_q[$];
  int         rx_cyc[$];
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_eop;

  // Bus monitor: accepted bytes ({eop,data}), done/overrun pulses, stall stability.
  always @(posedge clk) begin
    cyc++;
    if (n_rst !== 1'b1) prev_stall = 1'b0;
    else begin
      if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data || tx_eop !== prev_eop))
        stall_err++;
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        rx_q.push_back({tx_eop, tx_data});
        rx_cyc.push_back(cyc);
      end
      if (tx_done === 1'b1) done_cnt++;
      if (result_overrun === 1'b1) ovr_cnt++;
      prev_stall = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
      prev_data  = tx_data;
      prev_eop   = tx_eop;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    rx_q.delete(); rx_cyc.delete(); exp_q.delete();
    done_cnt = 0; ovr_cnt = 0; stall_err = 0;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && done_cnt < n; i++) step();
    ok = (done_cnt >= n);
  endtask

  // Reference: PID, nonce bytes LSB first, hash bytes LSB first, XOR of payload bytes.
  task automatic model_data(input logic [31:0] n, input logic [255:0] h);
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'hC3);
    for (int i = 0; i < 4; i++) begin exp_q.push_back(n[8*i +: 8]); x ^= n[8*i +: 8]; end
    for (int i = 0; i < 32; i++) begin exp_q.push_back(h[8*i +: 8]); x ^= h[8*i +: 8]; end
    exp_q.push_back(x);
  endtask

  task automatic pulse_result(input logic [31:0] n, input logic [255:0] h);
    nonce = n; hash = h; result_valid = 1'b1;
    step();
    result_valid = 1'b0; nonce = $urandom; hash = {8{$urandom}};
  endtask

  function automatic logic [255:0] ramp_hash();
    logic [255:0] h;
    for (int i = 0; i < 32; i++) h[8*i +: 8] = 8'(i + 1);
    return h;
  endfunction

  task automatic test_reset();
    n_rst = 1'b0; transmit_ack = 0; transmit_nack = 0; result_valid = 0;
    tx_ready = 1'b1; nonce = '0; hash = '0;
    repeat (2) step();
    checks++;
    if ({tx_valid, tx_data, tx_eop, tx_done, result_overrun} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=000", {tx_valid, tx_data, tx_eop, tx_done, result_overrun});
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_rst = 1'b1;
    step();
  endtask

  task automatic test_ack();
    clear_mon();
    transmit_ack = 1'b1;
    step();
    transmit_ack = 1'b0;
    checks++;
    if ({tx_valid, tx_data, tx_eop} !== {1'b1, 8'hD2, 1'b1}) begin
      failures++;
      $display("FAIL ack_first_cycle got=%b/%h/%b exp=1/d2/1", tx_valid, tx_data, tx_eop);
    end
    step();
    checks++;
    if (tx_done !== 1'b1 || tx_valid !== 1'b0) begin
      failures++; $display("FAIL ack_done got done=%b valid=%b exp 1/0", tx_done, tx_valid);
    end
    step();
    checks++;
    if (busy !== 1'b0 || tx_done !== 1'b0) begin
      failures++; $display("FAIL ack_after got busy=%b done=%b exp 0/0", busy, tx_done);
    end
  endtask

  task automatic test_nack_ack_same();
    bit ok;
    clear_mon();
    transmit_ack = 1'b1; transmit_nack = 1'b1;
    step();
    transmit_ack = 1'b0; transmit_nack = 1'b0;
    wait_done(2, 30, ok);
    repeat (8) step();
    checks++;
    if (!ok) begin failures++; $display("FAIL nack_ack_timeout done=%0d exp=2", done_cnt); end
    checks++;
    if (rx_q.size() != 2 || done_cnt != 2) begin
      failures++; $display("FAIL nack_ack_count bytes=%0d done=%0d exp 2/2", rx_q.size(), done_cnt);
    end else begin
      checks++;
      if (rx_q[0] !== 9'h15A || rx_q[1] !== 9'h1D2) begin
        failures++; $display("FAIL nack_ack_order got=%h,%h exp=15a,1d2", rx_q[0], rx_q[1]);
      end
      checks++;
      if (rx_cyc[1] - rx_cyc[0] != 2) begin
        failures++; $display("FAIL nack_ack_gap got=%0d exp=2", rx_cyc[1] - rx_cyc[0]);
      end
    end
  endtask

  task automatic test_data_fixed();
    bit ok;
    clear_mon();
    model_data(32'h12345678, ramp_hash());
    pulse_result(32'h12345678, ramp_hash());
    wait_done(1, 100, ok);
    repeat (5) step();
    checks++;
    if (!ok || rx_q.size() != 38) begin
      failures++; $display("FAIL data_fixed_len got=%0d exp=38 done_ok=%0b", rx_q.size(), ok);
    end else begin
      for (int i = 0; i < 38; i++) begin
        checks++;
        if (rx_q[i] !== {(i == 37), exp_q[i]}) begin
          failures++; $display("FAIL data_fixed_byte%0d got=%h exp=%h", i, rx_q[i], {(i == 37), exp_q[i]});
        end
      end
      checks++;
      if (rx_cyc[37] - rx_cyc[0] != 37) begin
        failures++; $display("FAIL data_fixed_gapless span=%0d exp=37", rx_cyc[37] - rx_cyc[0]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL data_fixed_busy got=%b exp=0", busy); end
  endtask

  task automatic test_data_stall();
    logic [31:0]  n;
    logic [255:0] h;
    for (int r = 0; r < 3; r++) begin
      clear_mon();
      n = (r == 0) ? 32'h12345678 : $urandom;
      h = (r == 0) ? ramp_hash() : {$urandom, $urandom, $urandom, $urandom,
                                     $urandom, $urandom, $urandom, $urandom};
      model_data(n, h);
      tx_ready = 1'($urandom);
      pulse_result(n, h);
      for (int i = 0; i < 400 && done_cnt < 1; i++) begin
        tx_ready = ($urandom_range(0, 2) != 0);
        step();
      end
      tx_ready = 1'b1;
      repeat (5) step();
      checks++;
      if (rx_q.size() != 38 || done_cnt != 1) begin
        failures++; $display("FAIL data_stall%0d_len got=%0d done=%0d exp 38/1", r, rx_q.size(), done_cnt);
      end else begin
        for (int i = 0; i < 38; i++) begin
          checks++;
          if (rx_q[i] !== {(i == 37), exp_q[i]}) begin
            failures++; $display("FAIL data_stall%0d_byte%0d got=%h exp=%h", r, i, rx_q[i], {(i == 37), exp_q[i]});
          end
        end
      end
      checks++;
      if (stall_err != 0) begin failures++; $display("FAIL data_stall%0d_hold got=%0d exp=0", r, stall_err); end
    end
  endtask

  task automatic test_overrun();
    bit ok;
    logic [31:0]  n;
    logic [255:0] h;
    clear_mon();
    n = $urandom; h = {8{$urandom}};
    model_data(n, h);
    pulse_result(n, h);
    repeat (6) step();
    pulse_result(~n, ~h);
    wait_done(1, 100, ok);
    repeat (60) step();
    checks++;
    if (ovr_cnt != 1) begin failures++; $display("FAIL overrun_pulses got=%0d exp=1", ovr_cnt); end
    checks++;
    if (!ok || done_cnt != 1 || rx_q.size() != 38) begin
      failures++; $display("FAIL overrun_single_pkt done=%0d bytes=%0d exp 1/38", done_cnt, rx_q.size());
    end else begin
      for (int i = 0; i < 38; i++) begin
        checks++;
        if (rx_q[i][7:0] !== exp_q[i]) begin
          failures++; $display("FAIL overrun_byte%0d got=%h exp=%h", i, rx_q[i][7:0], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0]  n;
    logic [255:0] h;
    clear_mon();
    n = $urandom; h = {8{$urandom}};
    model_data(n, h);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hD2);
    pulse_result(n, h);
    repeat (3) step();
    transmit_ack = 1'b1; step(); transmit_ack = 1'b0;
    repeat (4) step();
    transmit_ack = 1'b1; transmit_nack = 1'b1; step();
    transmit_ack = 1'b0; transmit_nack = 1'b0;
    wait_done(3, 150, ok);
    repeat (10) step();
    checks++;
    if (!ok || done_cnt != 3 || rx_q.size() != 40) begin
      failures++; $display("FAIL b2b_count done=%0d bytes=%0d exp 3/40", done_cnt, rx_q.size());
    end else begin
      for (int i = 0; i < 40; i++) begin
        checks++;
        if (rx_q[i][7:0] !== exp_q[i]) begin
          failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, rx_q[i][7:0], exp_q[i]);
        end
      end
      checks++;
      if (rx_cyc[37] - rx_cyc[0] != 37 || rx_cyc[38] - rx_cyc[37] != 2 || rx_cyc[39] - rx_cyc[38] != 2) begin
        failures++;
        $display("FAIL b2b_gaps got=%0d/%0d/%0d exp=37/2/2",
                 rx_cyc[37] - rx_cyc[0], rx_cyc[38] - rx_cyc[37], rx_cyc[39] - rx_cyc[38]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int eops;
    clear_mon();
    pulse_result(32'h12345678, ramp_hash());
    for (int i = 0; i < 100 && rx_q.size() < 11; i++) step();
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({tx_valid, tx_data, tx_eop, tx_done, busy, result_overrun} !== 13'h0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h exp=0", {tx_valid, tx_data, tx_eop, tx_done, busy, result_overrun});
    end
    eops = 0;
    foreach (rx_q[i]) if (rx_q[i][8]) eops++;
    checks++;
    if (rx_q.size() != 11 || eops != 0) begin
      failures++; $display("FAIL midreset_partial bytes=%0d eops=%0d exp 11/0", rx_q.size(), eops);
    end
    repeat (2) step();
    n_rst = 1'b1;
    step();
    clear_mon();
    transmit_nack = 1'b1; step(); transmit_nack = 1'b0;
    wait_done(1, 20, ok);
    repeat (20) step();
    checks++;
    if (!ok || rx_q.size() != 1 || done_cnt != 1) begin
      failures++; $display("FAIL midreset_nack_count bytes=%0d done=%0d exp 1/1", rx_q.size(), done_cnt);
    end else begin
      checks++;
      if (rx_q[0] !== 9'h15A) begin failures++; $display("FAIL midreset_nack_byte got=%h exp=15a", rx_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_nack_ack_same();
    test_data_fixed();
    test_data_stall();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
